// File: rtl/msu_sync_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO with first-word-fall-through or registered read, registered
// status flags and sticky overflow/underflow indicators.
module msu_sync_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 10,
   parameter int FWFT      = 1,
   parameter int AFULL_TH  = 896,
   parameter int AEMPTY_TH = 128
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             flush,
   input  logic             wrreq,
   input  logic [WIDTH-1:0] data,
   input  logic             rdreq,
   output logic [WIDTH-1:0] q,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [DEPTH:0]   usedw,
   output logic             overflow,
   output logic             underflow
);

   localparam int ENTRIES = 1 << DEPTH;
   localparam logic [DEPTH:0] CAP = (DEPTH+1)'(ENTRIES);

   logic [WIDTH-1:0] mem_q [ENTRIES];
   logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH:0]   usedw_q, usedw_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_en, rd_en;

   always_comb begin
      wr_en       = wrreq && !full_q && !flush;
      rd_en       = rdreq && !empty_q && !flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      usedw_d     = usedw_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      q_d         = q_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         usedw_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         q_d         = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + DEPTH'(1);
         if (wr_en && !rd_en)
            usedw_d = usedw_q + (DEPTH+1)'(1);
         else if (rd_en && !wr_en)
            usedw_d = usedw_q - (DEPTH+1)'(1);
         if (wrreq && full_q)  overflow_d  = 1'b1;
         if (rdreq && empty_q) underflow_d = 1'b1;
         if (FWFT != 0) begin
            // The word being written is the next head when nothing else remains queued.
            if (usedw_d != '0)
               q_d = (wr_en && (rd_ptr_d == wr_ptr_q)) ? data : mem_q[rd_ptr_d];
         end else if (rd_en) begin
            q_d = mem_q[rd_ptr_q];
         end
      end
      full_d   = (usedw_d == CAP);
      empty_d  = (usedw_d == '0);
      afull_d  = (32'(usedw_d) >= 32'(AFULL_TH));
      aempty_d = (32'(usedw_d) <= 32'(AEMPTY_TH));
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= data;
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         usedw_q     <= '0;
         q_q         <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         usedw_q     <= usedw_d;
         q_q         <= q_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign q            = q_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign usedw        = usedw_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_msu_sync_fifo.sv
`timescale 1ns/1ps
// Bench for msu_sync_fifo: FWFT instance checked against a scoreboard queue,
// registered-read instance checked for its one-cycle read latency.
module tb_msu_sync_fifo;
   localparam int W   = 8;
   localparam int D   = 4;
   localparam int CAP = 16;
   localparam int AF  = 12;
   localparam int AE  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic aclr_n = 1'b1;

   logic         a_flush = 0, a_wrreq = 0, a_rdreq = 0;
   logic [W-1:0] a_data = '0, a_q;
   logic         a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
   logic [D:0]   a_usedw;

   logic         b_flush = 0, b_wrreq = 0, b_rdreq = 0;
   logic [W-1:0] b_data = '0, b_q;
   logic         b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
   logic [D:0]   b_usedw;

   msu_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_a (
      .clk(clk), .aclr_n(aclr_n), .flush(a_flush), .wrreq(a_wrreq), .data(a_data),
      .rdreq(a_rdreq), .q(a_q), .full(a_full), .empty(a_empty), .almost_full(a_afull),
      .almost_empty(a_aempty), .usedw(a_usedw), .overflow(a_ovf), .underflow(a_udf));

   msu_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_b (
      .clk(clk), .aclr_n(aclr_n), .flush(b_flush), .wrreq(b_wrreq), .data(b_data),
      .rdreq(b_rdreq), .q(b_q), .full(b_full), .empty(b_empty), .almost_full(b_afull),
      .almost_empty(b_aempty), .usedw(b_usedw), .overflow(b_ovf), .underflow(b_udf));

   int checks = 0;
   int failures = 0;
   logic [W-1:0] sb [$];
   bit m_ovf = 0, m_udf = 0;
   logic [W-1:0] g, e;
   bit k;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock of stimulus on instance A; the model is advanced from pre-edge state.
   task automatic step_a(input bit w, input bit r, input logic [W-1:0] d,
                         output logic [W-1:0] got, output logic [W-1:0] exp, output bit racc);
      bit wacc;
      a_wrreq = w; a_rdreq = r; a_data = d;
      wacc = w && (sb.size() != CAP);
      racc = r && (sb.size() != 0);
      if (w && !wacc) m_ovf = 1;
      if (r && !racc) m_udf = 1;
      got = a_q;
      exp = '0;
      if (racc) exp = sb.pop_front();
      if (wacc) sb.push_back(d);
      @(posedge clk); #1;
      a_wrreq = 0; a_rdreq = 0;
   endtask

   task automatic flush_a(input bit w, input bit r, input logic [W-1:0] d);
      a_flush = 1; a_wrreq = w; a_rdreq = r; a_data = d;
      @(posedge clk); #1;
      a_flush = 0; a_wrreq = 0; a_rdreq = 0;
      sb.delete(); m_ovf = 0; m_udf = 0;
   endtask

   task automatic test_reset();
      #1 aclr_n = 0;
      #10;
      checks++; if (a_usedw !== 0)   begin failures++; $display("FAIL reset_usedw got=%0d exp=0", a_usedw); end
      checks++; if (a_empty !== 1'b1 || a_aempty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b%b exp=11", a_empty, a_aempty); end
      checks++; if (a_full !== 1'b0 || a_afull !== 1'b0) begin failures++; $display("FAIL reset_full got=%b%b exp=00", a_full, a_afull); end
      checks++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", a_ovf, a_udf); end
      checks++; if (a_q !== 0 || b_q !== 0) begin failures++; $display("FAIL reset_q got=%h/%h exp=00/00", a_q, b_q); end
      @(posedge clk); #1;
      aclr_n = 1;
   endtask

   task automatic test_basic();
      step_a(1, 0, 8'h11, g, e, k);
      checks++; if (a_empty !== 1'b0 || a_q !== 8'h11) begin failures++; $display("FAIL basic_first got empty=%b q=%h exp empty=0 q=11", a_empty, a_q); end
      step_a(1, 0, 8'h22, g, e, k);
      step_a(1, 0, 8'h33, g, e, k);
      checks++; if (a_usedw !== 3) begin failures++; $display("FAIL basic_usedw got=%0d exp=3", a_usedw); end
      for (int i = 0; i < 3; i++) begin
         step_a(0, 1, 8'h00, g, e, k);
         checks++; if (!k || g !== e) begin failures++; $display("FAIL basic_read%0d got=%h exp=%h", i, g, e); end
      end
      checks++; if (a_empty !== 1'b1 || a_udf !== 1'b0) begin failures++; $display("FAIL basic_end got empty=%b udf=%b exp 1 0", a_empty, a_udf); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 17; i++) begin
         step_a(1, 0, 8'(8'h40 + i), g, e, k);
         if (i == 15) begin
            checks++; if (a_full !== 1'b1 || a_usedw !== 16 || a_ovf !== 1'b0) begin failures++; $display("FAIL fill_full got full=%b usedw=%0d ovf=%b exp 1 16 0", a_full, a_usedw, a_ovf); end
         end
      end
      checks++; if (a_ovf !== 1'b1 || a_usedw !== 16) begin failures++; $display("FAIL fill_ovf got ovf=%b usedw=%0d exp 1 16", a_ovf, a_usedw); end
      for (int i = 0; i < 16; i++) begin
         step_a(0, 1, 8'h00, g, e, k);
         checks++; if (!k || g !== e) begin failures++; $display("FAIL fill_read%0d got=%h exp=%h", i, g, e); end
      end
      checks++; if (a_udf !== 1'b0 || a_empty !== 1'b1) begin failures++; $display("FAIL fill_end got udf=%b empty=%b exp 0 1", a_udf, a_empty); end
   endtask

   task automatic test_simultaneous();
      flush_a(0, 0, 8'h00);
      for (int i = 0; i < 16; i++) step_a(1, 0, 8'(8'h60 + i), g, e, k);
      step_a(1, 1, 8'hEE, g, e, k);
      checks++; if (a_usedw !== 5'(sb.size()) || a_usedw !== 15 || a_ovf !== 1'b1) begin failures++; $display("FAIL simul_full got usedw=%0d ovf=%b exp 15 1", a_usedw, a_ovf); end
      checks++; if (a_q !== sb[0]) begin failures++; $display("FAIL simul_full_q got=%h exp=%h", a_q, sb[0]); end
      for (int i = 0; i < 15; i++) begin
         step_a(0, 1, 8'h00, g, e, k);
         checks++; if (!k || g !== e) begin failures++; $display("FAIL simul_drain%0d got=%h exp=%h", i, g, e); end
      end
      step_a(1, 1, 8'h5A, g, e, k);
      checks++; if (a_usedw !== 1 || a_udf !== 1'b1 || a_q !== 8'h5A) begin failures++; $display("FAIL simul_empty got usedw=%0d udf=%b q=%h exp 1 1 5a", a_usedw, a_udf, a_q); end
      // streaming at one entry: acknowledge the head while writing its successor
      step_a(1, 1, 8'h5B, g, e, k);
      checks++; if (!k || g !== e || a_q !== 8'h5B || a_usedw !== 1) begin failures++; $display("FAIL simul_stream got ack=%h q=%h usedw=%0d exp ack=%h q=5b usedw=1", g, a_q, a_usedw, e); end
   endtask

   task automatic test_thresholds();
      int nw, nr, guard;
      flush_a(0, 0, 8'h00);
      for (int c = 0; c <= CAP; c++) begin
         checks++;
         if (a_usedw !== 5'(c) || a_aempty !== (c <= AE) || a_afull !== (c >= AF) || a_full !== (c == CAP) || a_empty !== (c == 0)) begin
            failures++;
            $display("FAIL thresh_up%0d got usedw=%0d ae=%b af=%b full=%b empty=%b", c, a_usedw, a_aempty, a_afull, a_full, a_empty);
         end
         if (c < CAP) step_a(1, 0, 8'(8'h90 + c), g, e, k);
      end
      for (int c = CAP; c > 0; c--) begin
         step_a(0, 1, 8'h00, g, e, k);
         checks++;
         if (!k || g !== e || a_aempty !== ((c - 1) <= AE) || a_afull !== ((c - 1) >= AF)) begin
            failures++;
            $display("FAIL thresh_down%0d got q=%h ae=%b af=%b exp q=%h", c - 1, g, a_aempty, a_afull, e);
         end
      end
      nw = 0; nr = 0; guard = 0;
      while ((nw < 40 || sb.size() != 0) && guard < 400) begin
         bit w, r;
         w = (nw < 40) && (sb.size() < CAP) && ($urandom_range(0, 2) != 0);
         r = (sb.size() != 0) && ($urandom_range(0, 1) != 0);
         step_a(w, r, 8'(8'h80 + nw), g, e, k);
         if (w) nw++;
         if (k) begin
            nr++;
            checks++; if (g !== e) begin failures++; $display("FAIL wrap_read%0d got=%h exp=%h", nr, g, e); end
         end
         guard++;
      end
      checks++; if (nr !== 40 || a_empty !== 1'b1 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin failures++; $display("FAIL wrap_count got reads=%0d empty=%b exp 40 1", nr, a_empty); end
   endtask

   task automatic test_std_read();
      b_wrreq = 1; b_data = 8'hA5;
      @(posedge clk); #1;
      b_wrreq = 0;
      checks++; if (b_q !== 8'h00 || b_empty !== 1'b0 || b_usedw !== 1) begin failures++; $display("FAIL std_prewrite got q=%h empty=%b usedw=%0d exp 00 0 1", b_q, b_empty, b_usedw); end
      b_rdreq = 1;
      @(posedge clk); #1;
      b_rdreq = 0;
      checks++; if (b_q !== 8'hA5 || b_empty !== 1'b1) begin failures++; $display("FAIL std_read got q=%h empty=%b exp a5 1", b_q, b_empty); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (b_q !== 8'hA5) begin failures++; $display("FAIL std_hold%0d got=%h exp=a5", i, b_q); end
      end
      b_rdreq = 1;
      @(posedge clk); #1;
      b_rdreq = 0;
      checks++; if (b_q !== 8'hA5 || b_udf !== 1'b1 || b_ovf !== 1'b0) begin failures++; $display("FAIL std_underflow got q=%h udf=%b ovf=%b exp a5 1 0", b_q, b_udf, b_ovf); end
      checks++; if (b_full !== 1'b0 || b_afull !== 1'b0 || b_aempty !== 1'b1) begin failures++; $display("FAIL std_flags got full=%b af=%b ae=%b exp 0 0 1", b_full, b_afull, b_aempty); end
   endtask

   task automatic test_flush_reset();
      flush_a(0, 0, 8'h00);
      for (int i = 0; i < 17; i++) step_a(1, 0, 8'(8'h20 + i), g, e, k);
      for (int i = 0; i < 7; i++) step_a(0, 1, 8'h00, g, e, k);
      checks++; if (a_usedw !== 9 || a_ovf !== 1'b1 || a_q !== sb[0]) begin failures++; $display("FAIL flush_pre got usedw=%0d ovf=%b q=%h exp 9 1 %h", a_usedw, a_ovf, a_q, sb[0]); end
      flush_a(1, 0, 8'hFF);
      checks++; if (a_usedw !== 0 || a_empty !== 1'b1 || a_q !== 8'h00 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin failures++; $display("FAIL flush_post got usedw=%0d empty=%b q=%h ovf=%b udf=%b exp 0 1 00 0 0", a_usedw, a_empty, a_q, a_ovf, a_udf); end
      for (int i = 0; i < 5; i++) step_a(1, 0, 8'(8'hD0 + i), g, e, k);
      checks++; if (a_usedw !== 5 || a_q !== 8'hD0) begin failures++; $display("FAIL pre_reset got usedw=%0d q=%h exp 5 d0", a_usedw, a_q); end
      #2 aclr_n = 0; a_wrreq = 1; a_rdreq = 0; a_data = 8'h77;
      #1;
      checks++; if (a_usedw !== 0 || a_empty !== 1'b1 || a_aempty !== 1'b1 || a_full !== 1'b0 || a_afull !== 1'b0 || a_q !== 8'h00 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin
         failures++; $display("FAIL async_reset got usedw=%0d empty=%b q=%h", a_usedw, a_empty, a_q);
      end
      for (int i = 0; i < 3; i++) begin
         a_rdreq = i[0];
         @(negedge clk);
         checks++; if (a_usedw !== 0 || a_empty !== 1'b1 || a_q !== 8'h00 || a_ovf !== 1'b0) begin failures++; $display("FAIL reset_hold%0d got usedw=%0d empty=%b q=%h", i, a_usedw, a_empty, a_q); end
      end
      sb.delete(); m_ovf = 0; m_udf = 0;
      a_rdreq = 0; a_wrreq = 1; a_data = 8'hC3;
      aclr_n = 1;
      sb.push_back(8'hC3);
      @(posedge clk); #1;
      a_wrreq = 0;
      checks++; if (a_usedw !== 5'(sb.size()) || a_q !== sb[0] || a_empty !== 1'b0) begin failures++; $display("FAIL first_write got usedw=%0d q=%h exp 1 c3", a_usedw, a_q); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_simultaneous();
      test_thresholds();
      test_std_read();
      test_flush_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
